// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared widths, reset defaults and FSM state encoding for the fetch stage
package if_fetch_pkg;
  localparam int INST_W = 32;
  localparam int ADDR_W = 64;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
  localparam logic [ADDR_W-1:0] INST_STEP_DEF = 64'd4;
  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_WAIT = 2'd2,
    IF_HOLD = 2'd3
  } if_state_e;
endpackage

// File: rtl/if_pcgen.sv
// if_pcgen: program counter register with trap > jump/branch > sequential priority
module if_pcgen
  import if_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [ADDR_W-1:0] INST_STEP = INST_STEP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trap_en_i,
  input  logic [ADDR_W-1:0] trap_addr_i,
  input  logic              jb_en_i,
  input  logic [ADDR_W-1:0] jb_addr_i,
  input  logic              adv_i,
  output logic [ADDR_W-1:0] pc_q
);
  logic [ADDR_W-1:0] pc_d;
  // next PC: redirect targets first, otherwise advance when a useful response lands
  always_comb begin
    pc_d = trap_en_i ? trap_addr_i : jb_en_i ? jb_addr_i : adv_i ? pc_q + INST_STEP : pc_q;
  end
  // PC register, reloaded with the boot address on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end
endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage; optional misaligned-PC trap via IF_FETCH_MISALIGN_CHK_EN
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [ADDR_W-1:0] INST_STEP = INST_STEP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_fetch_stall_i,
  input  logic              if_fetch_jumpbranch_en_i,
  input  logic [ADDR_W-1:0] if_fetch_jumpbranch_addr_i,
  input  logic              if_fetch_trap_en_i,
  input  logic [ADDR_W-1:0] if_fetch_trap_addr_i,
  output logic              if_fetch_req_o,
  output logic [ADDR_W-1:0] if_fetch_addr_o,
  input  logic              if_fetch_ready_i,
  input  logic              if_fetch_rvalid_i,
  input  logic [INST_W-1:0] if_fetch_rdata_i,
  output logic              if_fetch_inst_valid_o,
  output logic [INST_W-1:0] if_fetch_inst_o,
  output logic [ADDR_W-1:0] if_fetch_inst_addr_o,
  output logic [ADDR_W-1:0] if_fetch_nxt_inst_addr_o
`ifdef IF_FETCH_MISALIGN_CHK_EN
  ,
  output logic              if_fetch_misalign_o
`endif
);
  if_state_e state_q, state_d;
  logic discard_q, discard_d;
  logic skid_valid_q, skid_valid_d;
  logic [INST_W-1:0] skid_inst_q, skid_inst_d;
  logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;
  logic out_valid_q, out_valid_d;
  logic [INST_W-1:0] out_inst_q, out_inst_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d, out_nxt_q, out_nxt_d;
  logic mis_q, mis_d;
  logic [ADDR_W-1:0] pc_q;
  logic redirect, out_free, consumed, adv, mis_pc;

  assign redirect = if_fetch_trap_en_i | if_fetch_jumpbranch_en_i;
  assign out_free = !out_valid_q | !if_fetch_stall_i;
  assign consumed = out_valid_q & !if_fetch_stall_i;
  assign adv = (state_q == IF_WAIT) & if_fetch_rvalid_i & !discard_q;
`ifdef IF_FETCH_MISALIGN_CHK_EN
  assign mis_pc = pc_q[1:0] != 2'b00;
  assign if_fetch_misalign_o = mis_q;
`else
  assign mis_pc = 1'b0;
`endif
  assign if_fetch_req_o = (state_q == IF_REQ) & !mis_pc;
  assign if_fetch_addr_o = if_fetch_req_o ? pc_q : '0;
  assign if_fetch_inst_valid_o = out_valid_q;
  assign if_fetch_inst_o = out_inst_q;
  assign if_fetch_inst_addr_o = out_addr_q;
  assign if_fetch_nxt_inst_addr_o = out_nxt_q;

  if_pcgen #(.RESET_PC(RESET_PC), .INST_STEP(INST_STEP)) u_pcgen (
    .clk         (clk),
    .rst         (rst),
    .trap_en_i   (if_fetch_trap_en_i),
    .trap_addr_i (if_fetch_trap_addr_i),
    .jb_en_i     (if_fetch_jumpbranch_en_i),
    .jb_addr_i   (if_fetch_jumpbranch_addr_i),
    .adv_i       (adv),
    .pc_q        (pc_q)
  );

  // fetch FSM, skid and output register next-state; a redirect squashes everything last
  always_comb begin
    state_d      = state_q;
    discard_d    = discard_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_addr_d  = skid_addr_q;
    out_valid_d  = consumed ? 1'b0 : out_valid_q;
    out_inst_d   = out_inst_q;
    out_addr_d   = out_addr_q;
    out_nxt_d    = out_nxt_q;
    mis_d        = mis_q;
    case (state_q)
      IF_IDLE: state_d = IF_REQ;
      IF_REQ: begin
        if (if_fetch_ready_i && !mis_pc) begin
          state_d   = IF_WAIT;
          discard_d = redirect;
        end else if (mis_pc && !redirect && out_free) begin
          out_valid_d = 1'b1;
          out_inst_d  = '0;
          out_addr_d  = pc_q;
          out_nxt_d   = pc_q + INST_STEP;
          mis_d       = 1'b1;
          state_d     = IF_HOLD;
        end
      end
      IF_WAIT: begin
        if (if_fetch_rvalid_i && (discard_q || redirect)) begin
          discard_d = 1'b0;
          state_d   = IF_REQ;
        end else if (if_fetch_rvalid_i && out_free) begin
          out_valid_d = 1'b1;
          out_inst_d  = if_fetch_rdata_i;
          out_addr_d  = pc_q;
          out_nxt_d   = pc_q + INST_STEP;
          state_d     = IF_REQ;
        end else if (if_fetch_rvalid_i) begin
          skid_valid_d = 1'b1;
          skid_inst_d  = if_fetch_rdata_i;
          skid_addr_d  = pc_q;
          state_d      = IF_HOLD;
        end else if (redirect) begin
          discard_d = 1'b1;
        end
      end
      IF_HOLD: begin
        if (consumed && skid_valid_q && !mis_q) begin
          out_valid_d  = 1'b1;
          out_inst_d   = skid_inst_q;
          out_addr_d   = skid_addr_q;
          out_nxt_d    = skid_addr_q + INST_STEP;
          skid_valid_d = 1'b0;
          state_d      = IF_REQ;
        end
      end
      default: state_d = IF_IDLE;
    endcase
    if (redirect) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      mis_d        = 1'b0;
      state_d      = (state_q == IF_HOLD) ? IF_REQ : state_d;
    end
  end

  // state, skid and output registers, cleared asynchronously on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IF_IDLE;
      discard_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= '0;
      skid_addr_q  <= '0;
      out_valid_q  <= 1'b0;
      out_inst_q   <= '0;
      out_addr_q   <= '0;
      out_nxt_q    <= '0;
      mis_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      discard_q    <= discard_d;
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_addr_q  <= skid_addr_d;
      out_valid_q  <= out_valid_d;
      out_inst_q   <= out_inst_d;
      out_addr_q   <= out_addr_d;
      out_nxt_q    <= out_nxt_d;
      mis_q        <= mis_d;
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed cycle-by-cycle bench for if_fetch
module tb_if_fetch;
  logic clk, rst, stall, jb_en, tr_en, ready, rvalid;
  logic [63:0] jb_addr, tr_addr;
  logic [31:0] rdata;
  logic req, ival;
  logic [63:0] addr, iaddr, nxt;
  logic [31:0] inst;
`ifdef IF_FETCH_MISALIGN_CHK_EN
  logic mis;
`endif
  int n_cmp = 0;
  int n_err = 0;

  if_fetch dut (
    .clk                        (clk),
    .rst                        (rst),
    .if_fetch_stall_i           (stall),
    .if_fetch_jumpbranch_en_i   (jb_en),
    .if_fetch_jumpbranch_addr_i (jb_addr),
    .if_fetch_trap_en_i         (tr_en),
    .if_fetch_trap_addr_i       (tr_addr),
    .if_fetch_req_o             (req),
    .if_fetch_addr_o            (addr),
    .if_fetch_ready_i           (ready),
    .if_fetch_rvalid_i          (rvalid),
    .if_fetch_rdata_i           (rdata),
    .if_fetch_inst_valid_o      (ival),
    .if_fetch_inst_o            (inst),
    .if_fetch_inst_addr_o       (iaddr),
    .if_fetch_nxt_inst_addr_o   (nxt)
`ifdef IF_FETCH_MISALIGN_CHK_EN
    ,
    .if_fetch_misalign_o        (mis)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; stall = 0; jb_en = 0; tr_en = 0; ready = 0; rvalid = 0;
    jb_addr = '0; tr_addr = '0; rdata = '0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = 0; jb_en = 0; tr_en = 0; ready = 0; rvalid = 0;
    jb_addr = '0; tr_addr = '0; rdata = '0;
    step();
    step();
    n_cmp++;
    if ({req, addr, ival, inst, iaddr, nxt} !== '0) begin
      n_err++;
      $display("FAIL reset_outs: req=%b addr=%h v=%b inst=%h ia=%h nx=%h want all 0", req, addr, ival, inst, iaddr, nxt);
    end
`ifdef IF_FETCH_MISALIGN_CHK_EN
    n_cmp++;
    if (mis !== 1'b0) begin n_err++; $display("FAIL reset_mis: got %b want 0", mis); end
`endif
    rst = 1'b1;
    n_cmp++;
    if (req !== 1'b0) begin n_err++; $display("FAIL idle_req: got %b want 0", req); end
    step();
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      logic [63:0] a;
      a = 64'h8000_0000 + 64'(4 * i);
      n_cmp++;
      if (req !== 1'b1 || addr !== a) begin
        n_err++; $display("FAIL seq_req%0d: req=%b addr=%h want 1 %h", i, req, addr, a);
      end
      ready = 1; step(); ready = 0;
      n_cmp++;
      if (req !== 1'b0 || ival !== 1'b0) begin
        n_err++; $display("FAIL seq_wait%0d: req=%b v=%b want 0 0", i, req, ival);
      end
      rvalid = 1; rdata = 32'h0000_0013; step(); rvalid = 0;
      n_cmp++;
      if (ival !== 1'b1 || inst !== 32'h13 || iaddr !== a || nxt !== a + 64'd4) begin
        n_err++; $display("FAIL seq_out%0d: v=%b inst=%h ia=%h nx=%h want 1 13 %h %h", i, ival, inst, iaddr, nxt, a, a + 64'd4);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    ready = 1; step(); ready = 0;
    rvalid = 1; rdata = 32'h0000_0093; step(); rvalid = 0;
    stall = 1; ready = 1; step(); ready = 0;
    rvalid = 1; rdata = 32'h0010_0113; step(); rvalid = 0;
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (ival !== 1'b1 || inst !== 32'h93 || iaddr !== 64'h8000_0000 || req !== 1'b0) begin
        n_err++; $display("FAIL stall_hold%0d: v=%b inst=%h ia=%h req=%b want 1 93 80000000 0", j, ival, inst, iaddr, req);
      end
      if (j < 3) begin
        rvalid = (j == 0); rdata = 32'hffff_ffff; step(); rvalid = 0;
      end
    end
    stall = 0; step();
    n_cmp++;
    if (ival !== 1'b1 || inst !== 32'h0010_0113 || iaddr !== 64'h8000_0004 || nxt !== 64'h8000_0008) begin
      n_err++; $display("FAIL stall_skid: v=%b inst=%h ia=%h nx=%h want 1 00100113 80000004 80000008", ival, inst, iaddr, nxt);
    end
    n_cmp++;
    if (req !== 1'b1 || addr !== 64'h8000_0008) begin
      n_err++; $display("FAIL stall_resume: req=%b addr=%h want 1 80000008", req, addr);
    end
    ready = 1; step(); ready = 0;
    n_cmp++;
    if (ival !== 1'b0) begin n_err++; $display("FAIL stall_consume: v=%b want 0", ival); end
    rvalid = 1; rdata = 32'h0020_0193; step(); rvalid = 0;
    n_cmp++;
    if (ival !== 1'b1 || inst !== 32'h0020_0193 || iaddr !== 64'h8000_0008) begin
      n_err++; $display("FAIL stall_next: v=%b inst=%h ia=%h want 1 00200193 80000008", ival, inst, iaddr);
    end
  endtask

  task automatic test_jumpbranch();
    do_reset();
    ready = 1; step(); ready = 0;
    jb_en = 1; jb_addr = 64'h8000_1000; step(); jb_en = 0;
    n_cmp++;
    if (req !== 1'b0 || ival !== 1'b0) begin n_err++; $display("FAIL jb_wait: req=%b v=%b want 0 0", req, ival); end
    rvalid = 1; rdata = 32'hdead_beef; step(); rvalid = 0;
    n_cmp++;
    if (ival !== 1'b0 || req !== 1'b1 || addr !== 64'h8000_1000) begin
      n_err++; $display("FAIL jb_drop: v=%b req=%b addr=%h want 0 1 80001000", ival, req, addr);
    end
    ready = 1; step(); ready = 0;
    rvalid = 1; rdata = 32'h0000_006f; step(); rvalid = 0;
    n_cmp++;
    if (ival !== 1'b1 || inst !== 32'h6f || iaddr !== 64'h8000_1000 || nxt !== 64'h8000_1004) begin
      n_err++; $display("FAIL jb_fetch: v=%b inst=%h ia=%h nx=%h want 1 6f 80001000 80001004", ival, inst, iaddr, nxt);
    end
    stall = 1; jb_en = 1; jb_addr = 64'h8000_3000; step(); jb_en = 0; stall = 0;
    n_cmp++;
    if (ival !== 1'b0 || req !== 1'b1 || addr !== 64'h8000_3000) begin
      n_err++; $display("FAIL jb_over_stall: v=%b req=%b addr=%h want 0 1 80003000", ival, req, addr);
    end
  endtask

  task automatic test_trap_priority();
    tr_en = 1; tr_addr = 64'h8000_0100; jb_en = 1; jb_addr = 64'h8000_2000; step(); tr_en = 0; jb_en = 0;
    n_cmp++;
    if (req !== 1'b1 || addr !== 64'h8000_0100) begin
      n_err++; $display("FAIL trap_prio: req=%b addr=%h want 1 80000100", req, addr);
    end
    ready = 1; step(); ready = 0;
    rvalid = 1; rdata = 32'h1111_1111; jb_en = 1; jb_addr = 64'h8000_0200; step(); rvalid = 0; jb_en = 0;
    n_cmp++;
    if (ival !== 1'b0 || req !== 1'b1 || addr !== 64'h8000_0200) begin
      n_err++; $display("FAIL redir_rvalid: v=%b req=%b addr=%h want 0 1 80000200", ival, req, addr);
    end
    ready = 1; step(); ready = 0;
    rvalid = 1; rdata = 32'h0000_0033; step(); rvalid = 0;
    n_cmp++;
    if (ival !== 1'b1 || inst !== 32'h33 || iaddr !== 64'h8000_0200) begin
      n_err++; $display("FAIL redir_fetch: v=%b inst=%h ia=%h want 1 33 80000200", ival, inst, iaddr);
    end
  endtask

  task automatic test_wrap();
    jb_en = 1; jb_addr = 64'hffff_ffff_ffff_fffc; step(); jb_en = 0;
    n_cmp++;
    if (req !== 1'b1 || addr !== 64'hffff_ffff_ffff_fffc) begin
      n_err++; $display("FAIL wrap_req: req=%b addr=%h want 1 fffffffffffffffc", req, addr);
    end
    ready = 1; step(); ready = 0;
    rvalid = 1; rdata = 32'h13; step(); rvalid = 0;
    n_cmp++;
    if (iaddr !== 64'hffff_ffff_ffff_fffc || nxt !== 64'h0 || req !== 1'b1 || addr !== 64'h0) begin
      n_err++; $display("FAIL wrap_out: ia=%h nx=%h req=%b addr=%h want fffffffffffffffc 0 1 0", iaddr, nxt, req, addr);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    ready = 1; step(); ready = 0;
    rvalid = 1; rdata = 32'h13; step(); rvalid = 0;
    stall = 1; ready = 1; step(); ready = 0;
    n_cmp++;
    if (ival !== 1'b1) begin n_err++; $display("FAIL arst_pre: v=%b want 1", ival); end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({req, addr, ival, inst, iaddr, nxt} !== '0) begin
      n_err++; $display("FAIL arst_outs: req=%b addr=%h v=%b inst=%h ia=%h nx=%h want all 0", req, addr, ival, inst, iaddr, nxt);
    end
    stall = 0; step();
    rvalid = 1; rdata = 32'h0bad_0bad; rst = 1'b1; step();
    n_cmp++;
    if (ival !== 1'b0 || req !== 1'b1 || addr !== 64'h8000_0000) begin
      n_err++; $display("FAIL arst_first: v=%b req=%b addr=%h want 0 1 80000000", ival, req, addr);
    end
    step(); rvalid = 0;
    n_cmp++;
    if (ival !== 1'b0 || req !== 1'b1 || addr !== 64'h8000_0000) begin
      n_err++; $display("FAIL arst_late_rvalid: v=%b req=%b addr=%h want 0 1 80000000", ival, req, addr);
    end
  endtask

`ifdef IF_FETCH_MISALIGN_CHK_EN
  task automatic test_misalign();
    jb_en = 1; jb_addr = 64'h8000_0002; step(); jb_en = 0;
    n_cmp++;
    if (req !== 1'b0) begin n_err++; $display("FAIL mis_noreq: req=%b want 0", req); end
    step();
    n_cmp++;
    if (ival !== 1'b1 || inst !== 32'h0 || iaddr !== 64'h8000_0002 || mis !== 1'b1 || req !== 1'b0) begin
      n_err++; $display("FAIL mis_out: v=%b inst=%h ia=%h mis=%b req=%b want 1 0 80000002 1 0", ival, inst, iaddr, mis, req);
    end
    step();
    n_cmp++;
    if (req !== 1'b0 || mis !== 1'b1) begin n_err++; $display("FAIL mis_hold: req=%b mis=%b want 0 1", req, mis); end
    tr_en = 1; tr_addr = 64'h8000_0100; step(); tr_en = 0;
    n_cmp++;
    if (mis !== 1'b0 || req !== 1'b1 || addr !== 64'h8000_0100) begin
      n_err++; $display("FAIL mis_clear: mis=%b req=%b addr=%h want 0 1 80000100", mis, req, addr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_jumpbranch();
    test_trap_priority();
    test_wrap();
    test_async_reset();
`ifdef IF_FETCH_MISALIGN_CHK_EN
    test_misalign();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
